// File: rtl/sdm_cic_decim.sv
// N-stage CIC decimator: 1-bit sigma-delta stream in, saturated signed PCM out.
// Optional build macro SDM_CIC_ROUND_EN selects round-half-up scaling instead of floor.
module sdm_cic_decim #(
  parameter int N      = 4,
  parameter int LOG2_R = 6,
  parameter int OUT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic             din,
  output logic             valid_out,
  output logic [OUT_W-1:0] dout,
  output logic             clip
);

  localparam int G     = N * LOG2_R;
  localparam int ACC_W = G + 2;
  localparam int R     = 1 << LOG2_R;
  localparam int SH    = G - (OUT_W - 1);
  localparam int WU_W  = ($clog2(N + 1) > 3) ? $clog2(N + 1) : 3;

  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX;

  if (N < 1 || N > 8) begin : g_chk_n
    $error("sdm_cic_decim: N must be in 1..8");
  end
  if (R < N) begin : g_chk_r
    $error("sdm_cic_decim: decimation ratio must be >= N");
  end
  if (G < OUT_W - 1) begin : g_chk_g
    $error("sdm_cic_decim: N*LOG2_R must be >= OUT_W-1");
  end

  logic signed [ACC_W-1:0] r_integ [N];
  logic signed [ACC_W-1:0] w_x;
  logic [LOG2_R-1:0]       r_dec_cnt;
  logic                    r_dec_stb;
  logic [WU_W-1:0]         r_warm;
  logic signed [ACC_W-1:0] w_comb_out;
  logic signed [ACC_W:0]   w_shift;
  logic [OUT_W-1:0]        w_sat_val;
  logic                    w_sat;

  assign w_x = din ? {{(ACC_W - 1){1'b0}}, 1'b1} : {ACC_W{1'b1}};

  // Integrators wrap modulo 2**ACC_W by design; the comb differences undo the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) r_integ[k] <= '0;
    end else if (valid_in) begin
      r_integ[0] <= r_integ[0] + w_x;
      for (int k = 1; k < N; k++) r_integ[k] <= r_integ[k] + r_integ[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec_cnt <= '0;
      r_dec_stb <= 1'b0;
    end else begin
      r_dec_stb <= valid_in && (&r_dec_cnt);
      if (valid_in) r_dec_cnt <= r_dec_cnt + LOG2_R'(1);
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_comb
    logic signed [ACC_W-1:0] w_in;
    logic signed [ACC_W-1:0] w_y;
    logic signed [ACC_W-1:0] r_z;
    if (k == 0) begin : g_first
      assign w_in = r_integ[N-1];
    end else begin : g_next
      assign w_in = g_comb[k-1].w_y;
    end
    assign w_y = w_in - r_z;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         r_z <= '0;
      else if (r_dec_stb) r_z <= w_in;
    end
  end

  assign w_comb_out = g_comb[N-1].w_y;

`ifdef SDM_CIC_ROUND_EN
  if (SH > 0) begin : g_rnd
    localparam logic signed [ACC_W:0] RND = (ACC_W + 1)'(1) << (SH - 1);
    logic signed [ACC_W:0] w_rnd;
    assign w_rnd   = $signed({w_comb_out[ACC_W-1], w_comb_out}) + RND;
    assign w_shift = w_rnd >>> SH;
  end else begin : g_nornd
    assign w_shift = $signed({w_comb_out[ACC_W-1], w_comb_out});
  end
`else
  assign w_shift = $signed({w_comb_out[ACC_W-1], w_comb_out}) >>> SH;
`endif

  // Symmetric clamp keeps -max, not -2**(OUT_W-1), as the negative full scale.
  always_comb begin
    w_sat_val = w_shift[OUT_W-1:0];
    w_sat     = 1'b0;
    if (w_shift > SAT_MAX) begin
      w_sat_val = SAT_MAX[OUT_W-1:0];
      w_sat     = 1'b1;
    end else if (w_shift < SAT_MIN) begin
      w_sat_val = SAT_MIN[OUT_W-1:0];
      w_sat     = 1'b1;
    end
  end

  // The first N decimation events are still settling; output is released from event N+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_warm    <= '0;
      valid_out <= 1'b0;
      dout      <= '0;
      clip      <= 1'b0;
    end else begin
      valid_out <= r_dec_stb && (r_warm == WU_W'(N));
      if (r_dec_stb) begin
        dout <= w_sat_val;
        clip <= w_sat;
        if (r_warm != WU_W'(N)) r_warm <= r_warm + WU_W'(1);
      end
    end
  end

endmodule
